// File: rtl/vga_timing_pkg.sv
// Shared timing constants, axis FSM states and total-length helper for the
// 640x480@60 scan generator.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_state_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_scan_timing_if.sv
// Scan outputs bundle: counters and blank feed the renderers, syncs go to the connector.
interface vga_scan_timing_if;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_end;
  logic [7:0] frame_count;

  modport master (output DrawX, DrawY, blank, hs, vs, frame_end, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_end, frame_count);

endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: a wrapping 10-bit counter plus an ACTIVE/FRONT/SYNC/BACK region FSM
// whose state always describes the region the current count sits in.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int unsigned FP_LEN     = H_FP_DEF,
  parameter int unsigned SYNC_LEN   = H_SYNC_DEF,
  parameter int unsigned BP_LEN     = H_BP_DEF
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        advance,
  output logic [9:0]  count,
  output axis_state_t state,
  output logic        wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
  localparam logic [9:0] LAST     = 10'(TOTAL - 1);
  localparam logic [9:0] FRONT_AT = 10'(ACTIVE_LEN);
  localparam logic [9:0] SYNC_AT  = 10'(ACTIVE_LEN + FP_LEN);
  localparam logic [9:0] BACK_AT  = 10'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

  if (TOTAL > 1024 || TOTAL < 2) begin : g_bad_total
    $error("vga_axis_counter: axis total must be 2..1024");
  end

  logic [9:0]  count_d;
  axis_state_t state_d;

  assign wrap = advance && (count == LAST);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      state <= ACTIVE;
    end else begin
      count <= count_d;
      state <= state_d;
    end
  end

  // Region transitions key off the count we are about to enter, keeping state aligned with count.
  always_comb begin
    count_d = count;
    state_d = state;
    if (advance) begin
      count_d = wrap ? '0 : count + 10'd1;
      case (state)
        ACTIVE:  if (count_d == FRONT_AT) state_d = FRONT;
        FRONT:   if (count_d == SYNC_AT)  state_d = SYNC;
        SYNC:    if (count_d == BACK_AT)  state_d = BACK;
        BACK:    if (count_d == '0)       state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_scan_timing.sv
// 640x480@60 scan timing: raw counters/blank for the renderers, syncs delayed one clock
// to line up with the renderers' colour register, plus frame tick and frame counter.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  vga_scan_timing_if.master vga
);

  logic [9:0]  h_count, v_count;
  axis_state_t h_state, v_state;
  logic        h_wrap, v_wrap;
  logic        hs_q, vs_q, frame_end_q;
  logic [7:0]  frame_count_q;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP)
  ) u_h_axis (
    .vga_clk(vga_clk), .reset_n(reset_n), .advance(1'b1),
    .count(h_count), .state(h_state), .wrap(h_wrap)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP)
  ) u_v_axis (
    .vga_clk(vga_clk), .reset_n(reset_n), .advance(h_wrap),
    .count(v_count), .state(v_state), .wrap(v_wrap)
  );

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      frame_end_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hs_q        <= (h_state == SYNC) ? HS_POL : ~HS_POL;
      vs_q        <= (v_state == SYNC) ? VS_POL : ~VS_POL;
      frame_end_q <= (h_count == '0) && (v_count == 10'(V_ACTIVE));
      if (h_wrap && v_wrap) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign vga.DrawX       = h_count;
  assign vga.DrawY       = v_count;
  assign vga.blank       = (h_state == ACTIVE) && (v_state == ACTIVE);
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.frame_end   = frame_end_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboarded bench: a default-timing instance and a 10x10 small instance run side by side
// against an arithmetic model of scan position derived from the clock count since reset.
module tb_vga_scan_timing;

  logic vga_clk = 1'b0;
  logic rst_d = 1'b0;
  logic rst_s = 1'b0;
  always #5 vga_clk = ~vga_clk;

  vga_scan_timing_if vif_d ();
  vga_scan_timing_if vif_s ();

  vga_scan_timing dut_d (.vga_clk(vga_clk), .reset_n(rst_d), .vga(vif_d));

  vga_scan_timing #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (.vga_clk(vga_clk), .reset_n(rst_s), .vga(vif_s));

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fe;
    logic [7:0] fc;
  } obs_t;

  obs_t q_d[$];
  obs_t q_s[$];
  int   td, ts;
  int   passed, total;

  // Expected outputs t clocks after reset release (t=0 is the reset state).
  function automatic obs_t model(int ha, int hf, int hy, int hb, int va, int vf, int vy, int vb, int t);
    int   ht = ha + hf + hy + hb;
    int   vt = va + vf + vy + vb;
    int   px, py;
    obs_t m;
    m.x     = 10'(t % ht);
    m.y     = 10'((t / ht) % vt);
    m.blank = ((t % ht) < ha) && (((t / ht) % vt) < va);
    if (t == 0) begin
      m.hs = 1'b1; m.vs = 1'b1; m.fe = 1'b0;
    end else begin
      px   = (t - 1) % ht;
      py   = ((t - 1) / ht) % vt;
      m.hs = !(px >= ha + hf && px < ha + hf + hy);
      m.vs = !(py >= va + vf && py < va + vf + vy);
      m.fe = (px == 0) && (py == va);
    end
    m.fc = 8'((t / (ht * vt)) % 256);
    return m;
  endfunction

  function automatic obs_t sample_d();
    obs_t o;
    o.x = vif_d.DrawX; o.y = vif_d.DrawY; o.blank = vif_d.blank; o.hs = vif_d.hs;
    o.vs = vif_d.vs; o.fe = vif_d.frame_end; o.fc = vif_d.frame_count;
    return o;
  endfunction

  function automatic obs_t sample_s();
    obs_t o;
    o.x = vif_s.DrawX; o.y = vif_s.DrawY; o.blank = vif_s.blank; o.hs = vif_s.hs;
    o.vs = vif_s.vs; o.fe = vif_s.frame_end; o.fc = vif_s.frame_count;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cmp(input string who, input int t, input obs_t e, input obs_t o);
    chk($sformatf("%s t=%0d DrawX", who, t), 32'(o.x), 32'(e.x));
    chk($sformatf("%s t=%0d DrawY", who, t), 32'(o.y), 32'(e.y));
    chk($sformatf("%s t=%0d blank", who, t), 32'(o.blank), 32'(e.blank));
    chk($sformatf("%s t=%0d hs", who, t), 32'(o.hs), 32'(e.hs));
    chk($sformatf("%s t=%0d vs", who, t), 32'(o.vs), 32'(e.vs));
    chk($sformatf("%s t=%0d frame_end", who, t), 32'(o.fe), 32'(e.fe));
    chk($sformatf("%s t=%0d frame_count", who, t), 32'(o.fc), 32'(e.fc));
  endtask

  // One clock: push expectations at the edge, pop and compare on the falling edge.
  task automatic tick();
    @(posedge vga_clk);
    if (rst_d) td++;
    if (rst_s) ts++;
    q_d.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, td));
    q_s.push_back(model(4, 2, 2, 2, 4, 2, 2, 2, ts));
    @(negedge vga_clk);
    cmp("dflt", td, q_d.pop_front(), sample_d());
    cmp("small", ts, q_s.pop_front(), sample_s());
  endtask

  initial begin
    int bl_cnt = 0, hs_cnt = 0, fe_cnt = 0, vs_cnt = 0, fc_at100 = 0, n;
    bit seen;
    passed = 0; total = 0; td = 0; ts = 0;

    repeat (5) tick();
    rst_d = 1'b1;
    rst_s = 1'b1;

    repeat (25600) begin
      tick();
      if (vif_d.DrawY == 10'd1) begin
        if (vif_d.blank) bl_cnt++;
        if (!vif_d.hs)   hs_cnt++;
      end
      if (vif_s.frame_end) fe_cnt++;
      if (!vif_s.vs)       vs_cnt++;
      if (ts == 100)       fc_at100 = int'(vif_s.frame_count);
    end
    chk("dflt line blank-high clocks", 32'(bl_cnt), 32'd640);
    chk("dflt line hs-low clocks", 32'(hs_cnt), 32'd96);
    chk("small frame_count after first frame", 32'(fc_at100), 32'd1);
    chk("small frame_end pulses in 256 frames", 32'(fe_cnt), 32'd256);
    chk("small vs-low clocks in 256 frames", 32'(vs_cnt), 32'd5120);
    chk("small frame_count wrap", 32'(vif_s.frame_count), 32'd0);
    chk("small DrawX at wrap", 32'(vif_s.DrawX), 32'd0);
    chk("small DrawY at wrap", 32'(vif_s.DrawY), 32'd0);

    n = 0;
    while ((ts % 100) != 77 && n < 200) begin
      tick();
      n++;
    end
    chk("small vs low before mid reset", 32'(vif_s.vs), 32'd0);
    #2 rst_s = 1'b0;
    #1;
    chk("async reset DrawX", 32'(vif_s.DrawX), 32'd0);
    chk("async reset DrawY", 32'(vif_s.DrawY), 32'd0);
    chk("async reset vs", 32'(vif_s.vs), 32'd1);
    chk("async reset hs", 32'(vif_s.hs), 32'd1);
    chk("async reset blank", 32'(vif_s.blank), 32'd1);
    chk("async reset frame_count", 32'(vif_s.frame_count), 32'd0);
    chk("async reset frame_end", 32'(vif_s.frame_end), 32'd0);
    ts = 0;
    tick();
    rst_s = 1'b1;

    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (!vif_s.vs) seen = 1'b1;
    end
    chk("clocks to first vs fall after reset", 32'(n), 32'd61);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Pixel-timing generator for the 640x480 @ 60 Hz display path, clocked by the 25 MHz pixel clock. It owns the horizontal and vertical scan counters and drives `DrawX`, `DrawY` and `blank` straight into the sprite renderers, which register their colour one clock later. It drives `hs` and `vs` to the VGA connector, delayed one clock to line up with that colour register. It also provides a once-per-frame `frame_end` tick and a free-running frame counter for animation and game-state logic.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 1'b0, asserted level of `hs`
- `VS_POL`, 1'b0, asserted level of `vs`

Ports:
- `vga_clk` in 1 pixel clock; one clock; all state on rising edge
- `reset_n` in 1 asynchronous, active-low reset
- `DrawX` out 10 current horizontal count, 0..H_TOTAL-1
- `DrawY` out 10 current vertical count, 0..V_TOTAL-1
- `blank` out 1 1 = visible region (DrawX<H_ACTIVE && DrawY<V_ACTIVE); renderers output colour only when high
- `hs` out 1 horizontal sync, registered, one clock behind DrawX
- `vs` out 1 vertical sync, registered, one clock behind DrawX
- `frame_end` out 1 single-clock pulse at the start of vertical blanking
- `frame_count` out 8 frames completed since reset; wraps 255->0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- `DrawX` and `DrawY` are the counter registers themselves.
- DrawX increments every clock. At H_TOTAL-1 it wraps to 0 and DrawY advances by one.
- DrawY wraps V_TOTAL-1 -> 0 only on the same clock that DrawX wraps.
- Each axis runs a four-state FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - For each axis, a transition occurs when the count moves into the next region: horizontal boundaries 640/656/752/0, vertical 480/490/492/0.
  - The vertical FSM advances only on the horizontal wrap.
- `blank` is decoded combinationally from both FSMs being in ACTIVE, so it is aligned with DrawX/DrawY.
- `hs` is registered: next hs = HS_POL when the horizontal FSM is in SYNC, else ~HS_POL. `vs` is built the same way from the vertical FSM.
- `frame_end` is registered: it goes high for one clock when the counters read (0, V_ACTIVE) on the previous clock.
- `frame_count` increments on the DrawX/DrawY wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- All counter arithmetic is unsigned, 10-bit. Parameter sums must fit in 10 bits; H_TOTAL, V_TOTAL ≤ 1024.

## Timing
- Reset values:
  - DrawX=0, DrawY=0, blank=1 (decoded from 0,0)
  - hs=~HS_POL, vs=~VS_POL
  - frame_end=0, frame_count=0
  - both FSMs in ACTIVE
- First rising edge after reset release moves DrawX to 1.
- Reset asserted mid-frame forces all of the above immediately, without waiting for a clock. Scanning restarts at (0,0) with no partial-sync glitch beyond the reset value.
- Latency: DrawX/DrawY/blank have 0 clocks of latency from the counters. hs/vs/frame_end have 1 clock.
- hs (default timing) is low while DrawX is 657..752 inclusive (96 clocks per line).
- vs falls at (DrawX,DrawY)=(1,490) and rises at (1,492), giving 2×800 clocks.
- Frame period is exactly H_TOTAL×V_TOTAL = 420000 clocks.

## Structure
- Package `vga_timing_pkg`:
  - default timing constants
  - `axis_state_t` enum {ACTIVE, FRONT, SYNC, BACK}
  - function computing a total from active/porch/sync widths
- Sub-module `vga_axis_counter`, instantiated twice (horizontal, vertical):
  - parameters: active/fp/sync/bp
  - inputs: `vga_clk`, `reset_n`, `advance`
  - outputs: `count`, `state`, `wrap`
  - horizontal instance: `advance`=1
  - vertical instance: `advance`=horizontal `wrap`
- The top level adds the hs/vs/frame_end registers and frame_count.

## Test plan
- Reset: hold reset_n=0 for 5 clocks -> DrawX=0, DrawY=0, hs=1, vs=1, frame_end=0, frame_count=0, blank=1.
- Line timing: run 800 clocks -> blank high for DrawX 0..639 and low for 640..799. hs=0 exactly for DrawX 657..752; DrawY increments as DrawX goes 799->0.
- Frame timing: run 420000 clocks -> vs low for exactly 1600 clocks, starting at (1,490). frame_end is high once, at (1,480). frame_count=1 at (0,0).
- Wrap: run 256 frames -> frame_count returns to 0; frame_end pulses 256 times.
- Mid-frame reset: assert reset_n=0 at (700,491) while vs is low -> vs=1 and counters=(0,0) within the same clock. After release, the first vs fall occurs 490×800+1 clocks later.
- Small override (all widths 4, 2, 2, 2 on both axes): H_TOTAL=V_TOTAL=10 -> frame period 100 clocks, hs low at DrawX 7..8, blank high only for DrawX<4 && DrawY<4.
